seven_seg_scanner: RTL and testbench



---
 rtl/seven_seg_pkg.sv | 56 +++++
 rtl/hex_to_seven_seg.sv | 20 ++
 rtl/seven_seg_scanner.sv | 168 ++++++++++++++++
 tb/tb_seven_seg_scanner.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seven_seg_pkg
// Purpose : Shared constants for 7-segment display blocks: digit count,
//           digit index width, segment bit positions and the hex-to-segment
//           lookup table (active-high, bit order {g,f,e,d,c,b,a}).
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package seven_seg_pkg;

  localparam int NUM_DIGITS  = 4;
  localparam int DIGIT_IDX_W = 2;
  localparam int NIBBLE_W    = 4;
  localparam int SEG_W       = 7;
  localparam int VALUE_W     = NUM_DIGITS * NIBBLE_W;

  typedef logic [DIGIT_IDX_W-1:0] digit_idx_t;
  typedef logic [SEG_W-1:0]       seg_t;

  // Segment bit positions inside a seg_t word.
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Entry i is the active-high pattern for hex digit i. The concatenation
  // lists entry 15 first so that HEX_SEG_TABLE[i] indexes naturally.
  localparam logic [15:0][SEG_W-1:0] HEX_SEG_TABLE = {
    7'b1110001,  // F
    7'b1111001,  // E
    7'b1011110,  // d
    7'b0111001,  // C
    7'b1111100,  // b
    7'b1110111,  // A
    7'b1101111,  // 9
    7'b1111111,  // 8
    7'b0000111,  // 7
    7'b1111101,  // 6
    7'b1101101,  // 5
    7'b1100110,  // 4
    7'b1001111,  // 3
    7'b1011011,  // 2
    7'b0000110,  // 1
    7'b0111111   // 0
  };

  function automatic seg_t hex_seg_lookup(input logic [NIBBLE_W-1:0] hex);
    return HEX_SEG_TABLE[hex];
  endfunction

endpackage
`default_nettype wire

// File: rtl/hex_to_seven_seg.sv
`default_nettype none
// ============================================================================
// Module  : hex_to_seven_seg
// Purpose : Combinational hex digit to 7-segment decoder, active-high output.
//           Reusable by any display block that needs hex glyphs.
// Ports   : hex  in  4  hex digit to decode
//           seg  out 7  active-high segment pattern {g,f,e,d,c,b,a}
// Rev     : 1.0  initial release
// ============================================================================
module hex_to_seven_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = hex_seg_lookup(hex);

endmodule
`default_nettype wire

// File: rtl/seven_seg_scanner.sv
`default_nettype none
// ============================================================================
// Module  : seven_seg_scanner
// Purpose : Drives a 4-digit multiplexed common-anode 7-segment display with
//           the hex value of a 16-bit word. Each digit slot lasts
//           DIGIT_CYCLES clocks; the first BLANK_CYCLES of every slot keep
//           all anodes off to suppress ghosting. The word is snapshotted once
//           per frame so a mid-scan update never shows a torn value.
//
// Build option:
//   SEVEN_SEG_LEADING_ZERO_BLANK_EN - when defined, digits 3..1 stay dark
//   while that nibble and every higher nibble of the snapshot are zero.
//   Digit 0 is always lit. Timing is unaffected.
//
// Ports   : clock        in   1  system clock, rising edge
//           reset_n      in   1  asynchronous active-low reset
//           value        in  16  word to display
//           enable       in   1  1 = scanning, 0 = display dark
//           segments     out  7  {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
//           anodes       out  4  digit select, bit 0 rightmost, polarity per
//                                AN_ACTIVE_LOW
//           frame_start  out  1  pulse in the cycle the snapshot loads
// Rev     : 1.0  initial release
// ============================================================================
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int DIGIT_CYCLES   = 50000,
  parameter int BLANK_CYCLES   = 500,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] value,
  input  logic        enable,
  output logic [6:0]  segments,
  output logic [3:0]  anodes,
  output logic        frame_start
);

  localparam int PRESC_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;

  localparam logic [PRESC_W-1:0] PRESC_LAST  = PRESC_W'(DIGIT_CYCLES - 1);
  localparam logic [PRESC_W-1:0] BLANK_LIMIT = PRESC_W'(BLANK_CYCLES);
  localparam digit_idx_t         LAST_DIGIT  = DIGIT_IDX_W'(NUM_DIGITS - 1);

  // XOR masks that turn active-high internal values into pin levels; they are
  // also the "everything off" pin levels used in reset and when disabled.
  localparam logic [SEG_W-1:0]      SEG_POL = (SEG_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [NUM_DIGITS-1:0] AN_POL  = (AN_ACTIVE_LOW  != 0) ? '1 : '0;

  // --------------------------------------------------------------------------
  // Scan state
  // --------------------------------------------------------------------------
  logic [PRESC_W-1:0]    prescaler;
  digit_idx_t            digit_idx;
  logic [VALUE_W-1:0]    snapshot;
  // Distinguishes "idle at digit 0" (after reset or while disabled) from
  // "scanning digit 0". The first enabled cycle out of idle starts a frame.
  logic                  running;

  logic                  presc_last;
  logic                  frame_wrap;
  logic                  load_snapshot;

  assign presc_last    = (prescaler == PRESC_LAST);
  assign frame_wrap    = running && presc_last && (digit_idx == LAST_DIGIT);
  // A new frame begins either on the 3 -> 0 wrap or when leaving idle.
  assign load_snapshot = enable && (!running || frame_wrap);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prescaler <= '0;
      digit_idx <= '0;
      running   <= 1'b0;
    end else if (!enable) begin
      prescaler <= '0;
      digit_idx <= '0;
      running   <= 1'b0;
    end else if (!running) begin
      prescaler <= '0;
      digit_idx <= '0;
      running   <= 1'b1;
    end else if (presc_last) begin
      prescaler <= '0;
      digit_idx <= digit_idx + 1'b1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // The snapshot deliberately survives enable=0; it is only replaced at the
  // start of a frame.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      snapshot    <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= load_snapshot;
      if (load_snapshot) begin
        snapshot <= value;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Digit decode
  // --------------------------------------------------------------------------
  logic [NIBBLE_W-1:0] cur_nibble;
  logic [SEG_W-1:0]    cur_seg;

  assign cur_nibble = snapshot[{digit_idx, 2'b00} +: NIBBLE_W];

  hex_to_seven_seg u_hex_dec (
    .hex (cur_nibble),
    .seg (cur_seg)
  );

  // Which digits may light at all within a frame.
  logic [NUM_DIGITS-1:0] digit_shown;

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  assign digit_shown[0] = 1'b1;
  for (genvar k = 1; k < NUM_DIGITS; k++) begin : g_lead_zero
    // Lit if any nibble from this one upward is non-zero.
    assign digit_shown[k] = |snapshot[VALUE_W-1 : NIBBLE_W*k];
  end
`else
  assign digit_shown = '1;
`endif

  // --------------------------------------------------------------------------
  // Registered outputs (one cycle behind the scan state)
  // --------------------------------------------------------------------------
  logic                  scanning;
  logic                  in_blank;
  logic [NUM_DIGITS-1:0] anode_next;
  logic [SEG_W-1:0]      seg_next;

  // Gating on enable as well as running makes the display go dark on the
  // very edge that samples enable=0.
  assign scanning = enable && running;
  assign in_blank = (prescaler < BLANK_LIMIT);

  always_comb begin
    anode_next = '0;
    seg_next   = '0;
    if (scanning) begin
      seg_next = cur_seg;
      if (!in_blank && digit_shown[digit_idx]) begin
        anode_next = NUM_DIGITS'(1) << digit_idx;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      anodes   <= AN_POL;
      segments <= SEG_POL;
    end else begin
      anodes   <= anode_next ^ AN_POL;
      segments <= seg_next ^ SEG_POL;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scanner.sv
`default_nettype none
// ============================================================================
// Module  : tb_seven_seg_scanner
// Purpose : Self-checking bench for seven_seg_scanner with DIGIT_CYCLES=4,
//           BLANK_CYCLES=1 and both polarities active-low.
// Rev     : 1.0  initial release
// ============================================================================
module tb_seven_seg_scanner;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [15:0] value;
  logic        enable;
  logic [6:0]  segments;
  logic [3:0]  anodes;
  logic        frame_start;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  seven_seg_scanner #(
    .DIGIT_CYCLES   (4),
    .BLANK_CYCLES   (1),
    .SEG_ACTIVE_LOW (1),
    .AN_ACTIVE_LOW  (1)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .value       (value),
    .enable      (enable),
    .segments    (segments),
    .anodes      (anodes),
    .frame_start (frame_start)
  );

  // Pin-level (inverted) segment codes.
  localparam logic [6:0] OFF = 7'b1111111;
  localparam logic [6:0] P1  = 7'b1111001;
  localparam logic [6:0] P2  = 7'b0100100;
  localparam logic [6:0] P3  = 7'b0110000;
  localparam logic [6:0] P4  = 7'b0011001;
  localparam logic [6:0] P8  = 7'b0000000;
  localparam logic [6:0] PA  = 7'b0001000;
  localparam logic [6:0] PB  = 7'b0000011;
  localparam logic [6:0] PC  = 7'b1000110;
  localparam logic [6:0] PD  = 7'b0100001;

  function automatic logic [6:0] pin_code(input logic [3:0] h);
    logic [6:0] c;
    case (h)
      4'h0: c = 7'b0111111;  4'h1: c = 7'b0000110;
      4'h2: c = 7'b1011011;  4'h3: c = 7'b1001111;
      4'h4: c = 7'b1100110;  4'h5: c = 7'b1101101;
      4'h6: c = 7'b1111101;  4'h7: c = 7'b0000111;
      4'h8: c = 7'b1111111;  4'h9: c = 7'b1101111;
      4'hA: c = 7'b1110111;  4'hB: c = 7'b1111100;
      4'hC: c = 7'b0111001;  4'hD: c = 7'b1011110;
      4'hE: c = 7'b1111001;  default: c = 7'b1110001;
    endcase
    return ~c;
  endfunction

  typedef struct {
    logic        en;
    logic [15:0] val;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        fs;
  } vec_t;

  vec_t vecs [33];

  task automatic check(input string name, input logic [3:0] an,
                       input logic [6:0] seg, input logic fs);
    n_cmp++;
    if (anodes !== an || segments !== seg || frame_start !== fs) begin
      n_bad++;
      $display("FAIL %s: got an=%b seg=%b fs=%b, want an=%b seg=%b fs=%b",
               name, anodes, segments, frame_start, an, seg, fs);
    end
  endtask

  // Inputs change at the falling edge; outputs are checked at the next one.
  task automatic step(input logic en, input logic [15:0] v);
    enable = en;
    value  = v;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic restart(input logic [15:0] v);
    step(1'b0, v);
    check("restart_off", 4'b1111, OFF, 1'b0);
    step(1'b1, v);
    check("restart_fs", 4'b1111, OFF, 1'b1);
  endtask

  // One full frame after restart(); mask says which digits may light.
  task automatic run_frame(input logic [15:0] v, input logic [3:0] mask);
    logic [3:0] exp_an;
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 4; c++) begin
        step(1'b1, v);
        exp_an = (c == 0 || !mask[s]) ? 4'b1111 : ~(4'b0001 << s);
        check($sformatf("frame_%h_d%0d_c%0d", v, s, c), exp_an,
              pin_code(v[4*s +: 4]), (s == 3 && c == 3));
      end
    end
  endtask

  initial begin
    vecs[0]  = '{1'b1, 16'h1234, 4'b1111, OFF, 1'b1};
    vecs[1]  = '{1'b1, 16'h1234, 4'b1111, P4,  1'b0};
    vecs[2]  = '{1'b1, 16'h1234, 4'b1110, P4,  1'b0};
    vecs[3]  = '{1'b1, 16'h1234, 4'b1110, P4,  1'b0};
    vecs[4]  = '{1'b1, 16'h1234, 4'b1110, P4,  1'b0};
    vecs[5]  = '{1'b1, 16'h1234, 4'b1111, P3,  1'b0};
    vecs[6]  = '{1'b1, 16'h1234, 4'b1101, P3,  1'b0};
    vecs[7]  = '{1'b1, 16'h1234, 4'b1101, P3,  1'b0};
    vecs[8]  = '{1'b1, 16'h1234, 4'b1101, P3,  1'b0};
    vecs[9]  = '{1'b1, 16'h1234, 4'b1111, P2,  1'b0};
    vecs[10] = '{1'b1, 16'hABCD, 4'b1011, P2,  1'b0};
    vecs[11] = '{1'b1, 16'hABCD, 4'b1011, P2,  1'b0};
    vecs[12] = '{1'b1, 16'hABCD, 4'b1011, P2,  1'b0};
    vecs[13] = '{1'b1, 16'hABCD, 4'b1111, P1,  1'b0};
    vecs[14] = '{1'b1, 16'hABCD, 4'b0111, P1,  1'b0};
    vecs[15] = '{1'b1, 16'hABCD, 4'b0111, P1,  1'b0};
    vecs[16] = '{1'b1, 16'hABCD, 4'b0111, P1,  1'b1};
    vecs[17] = '{1'b1, 16'hABCD, 4'b1111, PD,  1'b0};
    vecs[18] = '{1'b1, 16'hABCD, 4'b1110, PD,  1'b0};
    vecs[19] = '{1'b1, 16'hABCD, 4'b1110, PD,  1'b0};
    vecs[20] = '{1'b1, 16'hABCD, 4'b1110, PD,  1'b0};
    vecs[21] = '{1'b1, 16'hABCD, 4'b1111, PC,  1'b0};
    vecs[22] = '{1'b1, 16'hABCD, 4'b1101, PC,  1'b0};
    vecs[23] = '{1'b1, 16'hABCD, 4'b1101, PC,  1'b0};
    vecs[24] = '{1'b1, 16'hABCD, 4'b1101, PC,  1'b0};
    vecs[25] = '{1'b1, 16'hABCD, 4'b1111, PB,  1'b0};
    vecs[26] = '{1'b1, 16'hABCD, 4'b1011, PB,  1'b0};
    vecs[27] = '{1'b1, 16'hABCD, 4'b1011, PB,  1'b0};
    vecs[28] = '{1'b1, 16'hABCD, 4'b1011, PB,  1'b0};
    vecs[29] = '{1'b1, 16'hABCD, 4'b1111, PA,  1'b0};
    vecs[30] = '{1'b1, 16'hABCD, 4'b0111, PA,  1'b0};
    vecs[31] = '{1'b1, 16'hABCD, 4'b0111, PA,  1'b0};
    vecs[32] = '{1'b1, 16'hABCD, 4'b0111, PA,  1'b1};

    // Reset held with a non-zero value present.
    reset_n = 1'b0;
    enable  = 1'b1;
    value   = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check($sformatf("reset_hold_%0d", i), 4'b1111, OFF, 1'b0);
    end
    reset_n = 1'b1;

    // Two frames: 1234, then ABCD written mid-frame (visible only next frame).
    for (int i = 0; i < 33; i++) begin
      step(vecs[i].en, vecs[i].val);
      check($sformatf("vec_%0d", i), vecs[i].an, vecs[i].seg, vecs[i].fs);
    end

    // Enable gating: drop enable while digit 2 is lit.
    repeat (8) step(1'b1, 16'hABCD);
    step(1'b1, 16'hABCD);
    check("d2_blank", 4'b1111, PB, 1'b0);
    step(1'b1, 16'hABCD);
    check("d2_lit", 4'b1011, PB, 1'b0);
    step(1'b0, 16'hABCD);
    check("disable_first", 4'b1111, OFF, 1'b0);
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 16'h5678);
      check($sformatf("disabled_%0d", i), 4'b1111, OFF, 1'b0);
    end
    step(1'b1, 16'h5678);
    check("reenable_fs", 4'b1111, OFF, 1'b1);
    step(1'b1, 16'h5678);
    check("reenable_blank", 4'b1111, P8, 1'b0);
    step(1'b1, 16'h5678);
    check("reenable_d0", 4'b1110, P8, 1'b0);

    // Asynchronous reset between clock edges.
    #2 reset_n = 1'b0;
    #1 check("async_reset", 4'b1111, OFF, 1'b0);
    #1 reset_n = 1'b1;
    @(negedge clock);
    check("post_reset_fs", 4'b1111, OFF, 1'b1);
    step(1'b1, 16'h5678);
    check("post_reset_blank", 4'b1111, P8, 1'b0);

    // Leading zeros.
    restart(16'h0040);
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    run_frame(16'h0040, 4'b0011);
`else
    run_frame(16'h0040, 4'b1111);
`endif
    restart(16'h0000);
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    run_frame(16'h0000, 4'b0001);
`else
    run_frame(16'h0000, 4'b1111);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
